// File: rtl/fsk_pkg.sv
// fsk_pkg: shared constants, receiver state type and serial CRC-4 step for the FSK receive sequencer
package fsk_pkg;
  localparam int SYM_LEN = 256;
  localparam int PHASE_W = 8;
  localparam int CRC_W = 4;
  localparam logic [CRC_W-1:0] CRC4_POLY = 4'h3;
  typedef enum logic [2:0] {IDLE, HUNT, PAYLOAD, CRC, OUT} rx_state_t;
  function automatic logic [CRC_W-1:0] crc4_step(input logic [CRC_W-1:0] crc, input logic b);
    crc4_step = {crc[CRC_W-2:0], 1'b0} ^ ((crc[CRC_W-1] ^ b) ? CRC4_POLY : '0);
  endfunction
endpackage

// File: rtl/fsk_crc4_serial.sv
// fsk_crc4_serial: MSB-first serial CRC-4 (x^4+x+1) accumulator with clear and enable
module fsk_crc4_serial
  import fsk_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic             i_bit,
  output logic [CRC_W-1:0] o_crc
);
  logic [CRC_W-1:0] r_crc;
  // clear wins over a step so a new frame always starts from zero
  always_ff @(posedge clk) begin
    if (rst || i_clr) r_crc <= '0;
    else if (i_en) r_crc <= crc4_step(r_crc, i_bit);
  end
  assign o_crc = r_crc;
endmodule

// File: rtl/fsk_rx_sequencer.sv
// fsk_rx_sequencer: symbol phase, bit capture, sync hunt and frame assembly; optional FSK_RX_STATS_EN adds frame/CRC-error counters
module fsk_rx_sequencer
  import fsk_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int SYNC_W = 8,
  parameter logic [SYNC_W-1:0] SYNC_WORD = 8'hA5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sample_en,
  input  logic               start,
  input  logic               abort,
  input  logic               demod_bit,
  output logic [PHASE_W-1:0] phase,
  output logic               sym_strobe,
  output logic               busy,
  output logic [DATA_W-1:0]  frame_data,
  output logic               frame_crc_ok,
  output logic               frame_valid,
  input  logic               frame_ready
`ifdef FSK_RX_STATS_EN
  ,
  output logic [15:0]        frame_cnt,
  output logic [15:0]        crc_err_cnt
`endif
);
  rx_state_t          r_state;
  logic [PHASE_W-1:0] r_phase;
  logic               r_sym_strobe;
  logic               r_skip;
  logic [SYNC_W-1:0]  r_sync;
  logic [DATA_W-1:0]  r_data;
  logic [CRC_W-1:0]   r_rx_crc;
  logic [5:0]         r_bit_cnt;
  logic [DATA_W-1:0]  r_frame_data;
  logic               r_crc_ok;
  logic               r_frame_valid;
  logic               w_active;
  logic               w_cap;
  logic [SYNC_W-1:0]  w_sync_nx;
  logic [DATA_W-1:0]  w_data_nx;
  logic [CRC_W-1:0]   w_rx_crc_nx;
  logic [CRC_W-1:0]   w_crc;
  logic               w_match;
  logic               w_crc_en;
  logic               w_accept;
  assign w_active    = r_state == HUNT || r_state == PAYLOAD || r_state == CRC;
  assign w_cap       = sample_en && w_active && r_phase == '0;
  assign w_sync_nx   = SYNC_W'({r_sync, demod_bit});
  assign w_data_nx   = DATA_W'({r_data, demod_bit});
  assign w_rx_crc_nx = {r_rx_crc[CRC_W-2:0], demod_bit};
  assign w_match     = r_state == HUNT && w_cap && !r_skip && w_sync_nx == SYNC_WORD && !abort;
  assign w_crc_en    = r_state == PAYLOAD && w_cap && !abort;
  assign w_accept    = r_frame_valid && frame_ready;
  fsk_crc4_serial u_crc (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_match),
    .i_en  (w_crc_en),
    .i_bit (demod_bit),
    .o_crc (w_crc)
  );
  // receive FSM: the first capture after entering HUNT is stale correlator output and is dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_phase       <= '0;
      r_sym_strobe  <= 1'b0;
      r_skip        <= 1'b0;
      r_sync        <= '0;
      r_data        <= '0;
      r_rx_crc      <= '0;
      r_bit_cnt     <= '0;
      r_frame_data  <= '0;
      r_crc_ok      <= 1'b0;
      r_frame_valid <= 1'b0;
    end else if (abort) begin
      r_state       <= IDLE;
      r_phase       <= '0;
      r_sym_strobe  <= 1'b0;
      r_frame_valid <= 1'b0;
    end else begin
      r_sym_strobe <= w_cap;
      if (sample_en && w_active) r_phase <= r_phase + 1'b1;
      case (r_state)
        IDLE: if (start) begin
          r_state <= HUNT;
          r_skip  <= 1'b1;
          r_sync  <= '0;
        end
        HUNT: if (w_cap) begin
          r_skip <= 1'b0;
          if (!r_skip) r_sync <= w_sync_nx;
          if (w_match) begin
            r_state   <= PAYLOAD;
            r_bit_cnt <= '0;
          end
        end
        PAYLOAD: if (w_cap) begin
          r_data    <= w_data_nx;
          r_bit_cnt <= r_bit_cnt + 1'b1;
          if (r_bit_cnt == 6'(DATA_W - 1)) begin
            r_state   <= CRC;
            r_bit_cnt <= '0;
          end
        end
        CRC: if (w_cap) begin
          r_rx_crc  <= w_rx_crc_nx;
          r_bit_cnt <= r_bit_cnt + 1'b1;
          if (r_bit_cnt == 6'(CRC_W - 1)) begin
            r_state       <= OUT;
            r_phase       <= '0;
            r_bit_cnt     <= '0;
            r_frame_data  <= r_data;
            r_crc_ok      <= w_rx_crc_nx == w_crc;
            r_frame_valid <= 1'b1;
          end
        end
        OUT: if (w_accept) begin
          r_state       <= HUNT;
          r_phase       <= '0;
          r_frame_valid <= 1'b0;
          r_skip        <= 1'b1;
          r_sync        <= '0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
`ifdef FSK_RX_STATS_EN
  logic [15:0] r_frame_cnt;
  logic [15:0] r_crc_err_cnt;
  // saturating counts of accepted frames and of accepted frames that failed the CRC
  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_cnt   <= '0;
      r_crc_err_cnt <= '0;
    end else if (w_accept && !abort) begin
      r_frame_cnt   <= &r_frame_cnt ? r_frame_cnt : r_frame_cnt + 1'b1;
      r_crc_err_cnt <= (r_crc_ok || &r_crc_err_cnt) ? r_crc_err_cnt : r_crc_err_cnt + 1'b1;
    end
  end
  assign frame_cnt   = r_frame_cnt;
  assign crc_err_cnt = r_crc_err_cnt;
`endif
  assign phase        = r_phase;
  assign sym_strobe   = r_sym_strobe;
  assign busy         = r_state != IDLE;
  assign frame_data   = r_frame_data;
  assign frame_crc_ok = r_crc_ok;
  assign frame_valid  = r_frame_valid;
endmodule
